// File: rtl/temp_disp_pkg.sv
// Shared definitions for the temperature 7-segment display: FSM states, glyphs, defaults.
// StDiv exists only when TEMP_SEG7_FAHRENHEIT_EN is defined.
package temp_disp_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT = 200;
  localparam logic [3:0]  BCD_STEPS           = 4'd9;
  localparam logic [3:0]  DIV_STEPS           = 4'd12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StLoad = 2'd2
`ifdef TEMP_SEG7_FAHRENHEIT_EN
    , StDiv = 2'd3
`endif
  } disp_state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 9-bit operand to 3-digit BCD, one bit per cycle after start.
module bin2bcd_seq
  import temp_disp_pkg::*;
(
  input  logic        clk_200kHz,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  operand,
  output logic        done,
  output logic [11:0] bcd
);

  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] adj;
  logic [3:0]  cnt_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= operand;
      bcd_q <= '0;
      cnt_q <= BCD_STEPS;
    end else if (cnt_q != 4'd0) begin
      bcd_q <= {adj[10:0], bin_q[8]};
      bin_q <= {bin_q[7:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done = (cnt_q == 4'd1);
  assign bcd  = bcd_q;

endmodule

// File: rtl/temp_seg7_display.sv
// 8-bit deg C word to 4-digit multiplexed 7-segment display via a sequential BCD engine.
// Define TEMP_SEG7_FAHRENHEIT_EN to add the unit_f input and the C->F divider path.
module temp_seg7_display
  import temp_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk_200kHz,
  input  logic       reset,
  input  logic [7:0] temp_data,
`ifdef TEMP_SEG7_FAHRENHEIT_EN
  input  logic       unit_f,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  disp_state_e     state_q, state_d;
  logic [7:0]      cap_q;
  logic            loaded_q;
  logic            changed, capture, conv_start, load_en, unit_sel;
  logic [8:0]      operand;
  logic            bcd_done;
  logic [11:0]     bcd;
  logic [3:0][6:0] dig_q;
  logic [RefW-1:0] refresh_q;
  logic [1:0]      slot_q, slot_d;
  logic            wrap;
  logic [6:0]      seg_q;
  logic [3:0]      an_q;

`ifdef TEMP_SEG7_FAHRENHEIT_EN
  logic        unit_q;
  logic        div_last;
  logic [11:0] div_q, quot_d, dividend;
  logic [2:0]  rem_q, rem_d;
  logic [3:0]  div_cnt_q, trial, trial_sub;
  logic        qbit;
  logic [8:0]  f_operand;

  assign changed  = !loaded_q || (temp_data != cap_q) || (unit_f != unit_q);
  assign div_last = (div_cnt_q == DIV_STEPS - 4'd1);
  assign unit_sel = unit_q;
  assign operand  = (state_q == StDiv) ? f_operand : {1'b0, temp_data};
  // C*9 + 2, so that the /5 below rounds 1.8*C to nearest.
  assign dividend = {1'b0, temp_data, 3'b000} + {4'b0000, temp_data} + 12'd2;

  always_comb begin
    trial     = {rem_q, div_q[11]};
    trial_sub = trial - 4'd5;
    qbit      = (trial >= 4'd5);
    rem_d     = qbit ? trial_sub[2:0] : trial[2:0];
    quot_d    = {div_q[10:0], qbit};
    f_operand = quot_d[8:0] + 9'd32;
  end

  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      unit_q    <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
    end else if (capture) begin
      unit_q    <= unit_f;
      div_q     <= dividend;
      rem_q     <= '0;
      div_cnt_q <= '0;
    end else if (state_q == StDiv) begin
      div_q     <= quot_d;
      rem_q     <= rem_d;
      div_cnt_q <= div_cnt_q + 4'd1;
    end
  end
`else
  assign changed  = !loaded_q || (temp_data != cap_q);
  assign unit_sel = 1'b0;
  assign operand  = {1'b0, temp_data};
`endif

  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
`ifdef TEMP_SEG7_FAHRENHEIT_EN
        if (changed) state_d = unit_f ? StDiv : StConv;
`else
        if (changed) state_d = StConv;
`endif
      end
`ifdef TEMP_SEG7_FAHRENHEIT_EN
      StDiv:   if (div_last) state_d = StConv;
`endif
      StConv:  if (bcd_done) state_d = StLoad;
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // busy covers the pending-change cycle in IDLE so the reported window spans the full latency.
  always_comb begin
    busy       = 1'b1;
    capture    = 1'b0;
    conv_start = 1'b0;
    load_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy    = changed & ~reset;
        capture = changed;
`ifdef TEMP_SEG7_FAHRENHEIT_EN
        conv_start = changed & ~unit_f;
`else
        conv_start = changed;
`endif
      end
`ifdef TEMP_SEG7_FAHRENHEIT_EN
      StDiv:   conv_start = div_last;
`endif
      StLoad:  load_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      cap_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      if (capture) cap_q <= temp_data;
      if (load_en) loaded_q <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk_200kHz (clk_200kHz),
    .reset      (reset),
    .start      (conv_start),
    .operand    (operand),
    .done       (bcd_done),
    .bcd        (bcd)
  );

  // All four digits change together on LOAD, so a frame never mixes old and new values.
  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      dig_q <= {4{GLYPH_BLANK}};
    end else if (load_en) begin
      dig_q[3] <= (BLANK_LZ && bcd[11:8] == 4'd0) ? GLYPH_BLANK : digit_glyph(bcd[11:8]);
      dig_q[2] <= (BLANK_LZ && bcd[11:4] == 8'd0) ? GLYPH_BLANK : digit_glyph(bcd[7:4]);
      dig_q[1] <= digit_glyph(bcd[3:0]);
      dig_q[0] <= unit_sel ? GLYPH_F : GLYPH_C;
    end
  end

  assign wrap   = (refresh_q == RefW'(REFRESH_DIV - 1));
  assign slot_d = wrap ? slot_q - 2'd1 : slot_q;

  always_ff @(posedge clk_200kHz or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      slot_q    <= 2'd3;
      an_q      <= 4'hF;
      seg_q     <= GLYPH_BLANK;
    end else begin
      refresh_q <= wrap ? '0 : refresh_q + RefW'(1);
      slot_q    <= slot_d;
      an_q      <= ~(4'b0001 << slot_d);
      seg_q     <= dig_q[slot_d];
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_temp_seg7_display.sv
// Scoreboard bench: stimulus queues expected frames; a monitor checks each completed conversion.
`timescale 1ns/1ps
module tb_temp_seg7_display;

  localparam int RD = 200;
  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G4 = 7'h19, G5 = 7'h12;
  localparam logic [6:0] G7 = 7'h78, G9 = 7'h10, GC = 7'h46, GB = 7'h7F;
`ifdef TEMP_SEG7_FAHRENHEIT_EN
  localparam logic [6:0] GF = 7'h0E;
`endif

  typedef struct {
    logic [3:0][6:0] g;
    logic [3:0][6:0] gz;
    int              busy_len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] temp_data;
`ifdef TEMP_SEG7_FAHRENHEIT_EN
  logic       unit_f;
`endif
  logic [6:0] seg, seg_z;
  logic [3:0] an, an_z;
  logic       busy, busy_z;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_done   = 0;

  always #2500 clk = ~clk;

  temp_seg7_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
    .clk_200kHz (clk),
    .reset      (reset),
    .temp_data  (temp_data),
`ifdef TEMP_SEG7_FAHRENHEIT_EN
    .unit_f     (unit_f),
`endif
    .seg        (seg),
    .an         (an),
    .busy       (busy)
  );

  temp_seg7_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_z (
    .clk_200kHz (clk),
    .reset      (reset),
    .temp_data  (temp_data),
`ifdef TEMP_SEG7_FAHRENHEIT_EN
    .unit_f     (unit_f),
`endif
    .seg        (seg_z),
    .an         (an_z),
    .busy       (busy_z)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0][6:0] g, input logic [3:0][6:0] gz, input int len);
    exp_t e;
    e.g        = g;
    e.gz       = gz;
    e.busy_len = len;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic apply(input logic [7:0] v);
    @(posedge clk);
    #1 temp_data = v;
  endtask

  task automatic wait_monitor();
    int t = 0;
    while (n_done < n_pushed && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check("monitor_timeout", n_done, n_pushed);
  endtask

  // Monitor: measure each busy window, then read one full frame from both instances.
  initial begin : monitor
    int              len;
    exp_t            e;
    logic [3:0][6:0] got, gotz;
    logic [3:0]      seen, seenz, prev_an;
    int              oh_err, glitch_err, rot_err, last_chg, n_chg;
    bit              found;
    len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        len = 0;
      end else if (busy) begin
        len++;
      end else if (len > 0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: busy window of %0d cycles with nothing expected", len);
        end else begin
          e = sb_q.pop_front();
          check("busy_len", len, e.busy_len);
          repeat (2) @(negedge clk);
          seen = '0; seenz = '0; got = '0; gotz = '0;
          oh_err = 0; glitch_err = 0; rot_err = 0; last_chg = -1; n_chg = 0;
          prev_an = an;
          for (int c = 0; c < 4 * RD; c++) begin
            @(negedge clk);
            if (an !== prev_an) begin
              if (an !== {prev_an[0], prev_an[3:1]}) rot_err++;
              if (last_chg >= 0 && (c - last_chg) != RD) rot_err++;
              last_chg = c;
              n_chg++;
              prev_an = an;
            end
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
              if (an === ~(4'b0001 << k)) begin
                found = 1'b1;
                if (!seen[k]) begin
                  got[k]  = seg;
                  seen[k] = 1'b1;
                end else if (seg !== got[k]) begin
                  glitch_err++;
                end
              end
              if (an_z === ~(4'b0001 << k)) begin
                if (!seenz[k]) begin
                  gotz[k]  = seg_z;
                  seenz[k] = 1'b1;
                end else if (seg_z !== gotz[k]) begin
                  glitch_err++;
                end
              end
            end
            if (!found) oh_err++;
          end
          if (n_chg < 3) rot_err++;
          check("an_onehot_low", oh_err, 0);
          check("an_rotation", rot_err, 0);
          check("seg_stable", glitch_err, 0);
          check("slots_seen", {seen, seenz}, 8'hFF);
          check("hundreds", got[3], e.g[3]);
          check("tens", got[2], e.g[2]);
          check("ones", got[1], e.g[1]);
          check("unit", got[0], e.g[0]);
          check("lz_digits", gotz, e.gz);
          n_done++;
        end
        len = 0;
      end
    end
  end

  initial begin : stimulus
    int busy_seen;
    reset     = 1'b1;
    temp_data = 8'd25;
`ifdef TEMP_SEG7_FAHRENHEIT_EN
    unit_f    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_busy", busy, 1'b0);

    push({GB, G2, G5, GC}, {G0, G2, G5, GC}, 11);
    reset = 1'b0;
    wait_monitor();

    push({GB, GB, G0, GC}, {G0, G0, G0, GC}, 11);
    apply(8'd0);
    wait_monitor();

    // 100 arrives on CONV cycle 4 of the 255 pass; only the second pass is ever shown
    push({G1, G0, G0, GC}, {G1, G0, G0, GC}, 22);
    apply(8'd255);
    repeat (4) @(posedge clk);
    #1 temp_data = 8'd100;
    wait_monitor();

    push({G1, G0, G9, GC}, {G1, G0, G9, GC}, 11);
    apply(8'd109);
    wait_monitor();

    push({GB, GB, G7, GC}, {G0, G0, G7, GC}, 11);
    apply(8'd7);
    wait_monitor();

    apply(8'd7);
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("no_reconv_same_value", busy_seen, 0);

    push({G2, G5, G5, GC}, {G2, G5, G5, GC}, 11);
    apply(8'd255);
    wait_monitor();

    apply(8'd42);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midconv_rst_seg", seg, 7'h7F);
    check("midconv_rst_an", an, 4'hF);
    check("midconv_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    push({GB, G4, G2, GC}, {G0, G4, G2, GC}, 11);
    reset = 1'b0;
    wait_monitor();

`ifdef TEMP_SEG7_FAHRENHEIT_EN
    push({GB, G9, G9, GF}, {G0, G9, G9, GF}, 23);
    @(posedge clk);
    #1;
    unit_f    = 1'b1;
    temp_data = 8'd37;
    wait_monitor();

    push({G4, G9, G1, GF}, {G4, G9, G1, GF}, 23);
    apply(8'd255);
    wait_monitor();

    push({G2, G5, G5, GC}, {G2, G5, G5, GC}, 11);
    @(posedge clk);
    #1 unit_f = 1'b0;
    wait_monitor();
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
